// File: rtl/ring_output.sv
`default_nettype none
// ============================================================================
// Module   : ring_output
// Purpose  : Ring router output channel. Per-VC round-robin arbitration between
//            the PE and ring requesters, a one-entry buffer per VC, and a
//            polarity-split drain onto the outgoing link.
// Revision : 1.0 - initial release
// ============================================================================
module ring_output #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_MSB    = 55,
    parameter int HOP_LSB    = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_polarity,
    input  logic                  i_req_ring_even,
    input  logic                  i_req_ring_odd,
    input  logic                  i_req_pe_even,
    input  logic                  i_req_pe_odd,
    input  logic [DATA_WIDTH-1:0] i_data_ring_even,
    input  logic [DATA_WIDTH-1:0] i_data_ring_odd,
    input  logic [DATA_WIDTH-1:0] i_data_pe_even,
    input  logic [DATA_WIDTH-1:0] i_data_pe_odd,
    output logic                  o_grant_ring_even,
    output logic                  o_grant_ring_odd,
    output logic                  o_grant_pe_even,
    output logic                  o_grant_pe_odd,
    output logic                  o_so,
    input  logic                  i_ro,
    output logic [DATA_WIDTH-1:0] o_do
);

    // VC index 0 = even, 1 = odd. The internal VC index equals polarity.
    logic [1:0]            w_req_ring;
    logic [1:0]            w_req_pe;
    logic [DATA_WIDTH-1:0] w_data_ring [2];
    logic [DATA_WIDTH-1:0] w_data_pe   [2];
    logic [1:0]            w_gnt_ring;
    logic [1:0]            w_gnt_pe;
    logic [1:0]            w_full;
    logic [DATA_WIDTH-1:0] w_buf       [2];
    logic                  w_ext_idx;
    logic [DATA_WIDTH-1:0] w_out;

    assign w_req_ring     = {i_req_ring_odd, i_req_ring_even};
    assign w_req_pe       = {i_req_pe_odd, i_req_pe_even};
    assign w_data_ring[0] = i_data_ring_even;
    assign w_data_ring[1] = i_data_ring_odd;
    assign w_data_pe[0]   = i_data_pe_even;
    assign w_data_pe[1]   = i_data_pe_odd;
    assign w_ext_idx      = ~i_polarity;

    generate
        for (genvar v = 0; v < 2; v++) begin : g_vc
            localparam logic c_VC_ID = 1'(v);

            logic                  r_full;
            logic                  r_prio;
            logic [DATA_WIDTH-1:0] r_buf;
            logic                  w_fillable;
            logic                  w_fill;
            logic                  w_drain;

            assign w_fillable    = ~rst & ~r_full & (i_polarity == c_VC_ID);
            // prio=0 prefers ring, prio=1 prefers PE; only matters under contention
            assign w_gnt_ring[v] = w_fillable & w_req_ring[v] & (~w_req_pe[v] | ~r_prio);
            assign w_gnt_pe[v]   = w_fillable & w_req_pe[v] & (~w_req_ring[v] | r_prio);
            assign w_fill        = w_gnt_ring[v] | w_gnt_pe[v];
            assign w_drain       = o_so & (w_ext_idx == c_VC_ID);
            assign w_full[v]     = r_full;
            assign w_buf[v]      = r_buf;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_full <= 1'b0;
                    r_prio <= 1'b0;
                    r_buf  <= '0;
                end else if (w_fill) begin
                    r_full <= 1'b1;
                    r_buf  <= w_gnt_pe[v] ? w_data_pe[v] : w_data_ring[v];
                    if (w_req_ring[v] && w_req_pe[v]) begin
                        r_prio <= w_gnt_ring[v];
                    end
                end else if (w_drain) begin
                    r_full <= 1'b0;
                end
            end
        end
    endgenerate

    assign o_grant_ring_even = w_gnt_ring[0];
    assign o_grant_ring_odd  = w_gnt_ring[1];
    assign o_grant_pe_even   = w_gnt_pe[0];
    assign o_grant_pe_odd    = w_gnt_pe[1];

    assign o_so = w_full[w_ext_idx] & i_ro & ~rst;

    // Hop count is decremented by halving the hop field on the way out
    always_comb begin
        w_out                  = w_buf[w_ext_idx];
        w_out[HOP_MSB:HOP_LSB] = w_out[HOP_MSB:HOP_LSB] >> 1;
        o_do                   = o_so ? w_out : '0;
    end

endmodule
`default_nettype wire
